// File: rtl/sram_fill_verify_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_fill_verify_ctrl
// Description : Async-SRAM fill/verify engine with a seeded address pattern.
//               Optional first-error capture with SRAM_ERR_CAPTURE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_fill_verify_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic [1:0]        Mode,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic [ADDR_W-1:0] Last_Addr,
    input  logic [DATA_W-1:0] Seed,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic [15:0]       Err_Count,
    output logic [ADDR_W-1:0] SRAM_Address,
    inout  wire  [DATA_W-1:0] SRAM_Data,
    output logic              SRAM_Write_Enable,
    output logic              SRAM_Output_Enable,
    output logic              CS,
    output logic              HbMask,
    output logic              LbMask
`ifdef SRAM_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] First_Err_Addr,
    output logic [DATA_W-1:0] First_Err_Data
`endif
);

    localparam int c_WAIT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_CYC - 1);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_W_SETUP  = 3'd1;
    localparam logic [2:0] c_S_W_PULSE  = 3'd2;
    localparam logic [2:0] c_S_W_HOLD   = 3'd3;
    localparam logic [2:0] c_S_R_SETUP  = 3'd4;
    localparam logic [2:0] c_S_R_SAMPLE = 3'd5;
    localparam logic [2:0] c_S_DONE     = 3'd6;

    logic [2:0]          r_state;
    logic [c_WAIT_W-1:0] r_wait;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_last;
    logic [DATA_W-1:0]   r_seed;
    logic                r_verify;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_drive;
    logic                r_we_n;
    logic                r_oe_n;
    logic                r_cs_n;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [15:0]         r_err;

    logic [2:0]          w_nstate;
    logic [c_WAIT_W-1:0] w_nwait;
    logic [ADDR_W-1:0]   w_naddr;
    logic                w_accept;
    logic [DATA_W-1:0]   w_seed_eff;
    logic [DATA_W-1:0]   w_expect;
    logic                w_mismatch;
    logic [15:0]         w_err_next;
    logic                w_n_access;
    logic                w_n_read;
    logic                w_n_write;

    assign w_accept   = (r_state == c_S_IDLE) && Start && (Mode != 2'b00);
    assign w_seed_eff = w_accept ? Seed : r_seed;
    assign w_expect   = r_addr[DATA_W-1:0] ^ r_seed;
    assign w_mismatch = (r_state == c_S_R_SAMPLE) && (SRAM_Data != w_expect);
    assign w_err_next = (w_mismatch && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;

    always_comb begin
        w_nstate = r_state;
        w_nwait  = r_wait;
        w_naddr  = r_addr;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_nstate = Mode[0] ? c_S_W_SETUP : c_S_R_SETUP;
                    w_naddr  = Base_Addr;
                    w_nwait  = '0;
                end
            end
            c_S_W_SETUP: begin
                w_nstate = c_S_W_PULSE;
                w_nwait  = '0;
            end
            c_S_W_PULSE: begin
                if (r_wait == c_WAIT_LAST) w_nstate = c_S_W_HOLD;
                else                       w_nwait  = r_wait + 1'b1;
            end
            c_S_W_HOLD: begin
                if (r_addr != r_last) begin
                    w_nstate = c_S_W_SETUP;
                    w_naddr  = r_addr + 1'b1;
                end else if (r_verify) begin
                    // second pass of a fill+verify run starts over at the base
                    w_nstate = c_S_R_SETUP;
                    w_naddr  = r_base;
                    w_nwait  = '0;
                end else begin
                    w_nstate = c_S_DONE;
                end
            end
            c_S_R_SETUP: begin
                if (r_wait == c_WAIT_LAST) w_nstate = c_S_R_SAMPLE;
                else                       w_nwait  = r_wait + 1'b1;
            end
            c_S_R_SAMPLE: begin
                if (r_addr != r_last) begin
                    w_nstate = c_S_R_SETUP;
                    w_naddr  = r_addr + 1'b1;
                    w_nwait  = '0;
                end else begin
                    w_nstate = c_S_DONE;
                end
            end
            c_S_DONE: w_nstate = c_S_IDLE;
            default:  w_nstate = c_S_IDLE;
        endcase
    end

    assign w_n_write  = (w_nstate == c_S_W_SETUP) || (w_nstate == c_S_W_PULSE) ||
                        (w_nstate == c_S_W_HOLD);
    assign w_n_read   = (w_nstate == c_S_R_SETUP) || (w_nstate == c_S_R_SAMPLE);
    assign w_n_access = w_n_write || w_n_read;

    // Strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= c_S_IDLE;
            r_wait   <= '0;
            r_addr   <= '0;
            r_base   <= '0;
            r_last   <= '0;
            r_seed   <= '0;
            r_verify <= 1'b0;
            r_wdata  <= '0;
            r_drive  <= 1'b0;
            r_we_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_cs_n   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
        end else begin
            r_state <= w_nstate;
            r_wait  <= w_nwait;
            r_addr  <= w_naddr;
            r_drive <= w_n_write;
            r_we_n  <= (w_nstate != c_S_W_PULSE);
            r_oe_n  <= !w_n_read;
            r_cs_n  <= !w_n_access;
            r_busy  <= (w_nstate != c_S_IDLE) && (w_nstate != c_S_DONE);
            r_done  <= (w_nstate == c_S_DONE);
            if (w_nstate == c_S_W_SETUP) r_wdata <= w_naddr[DATA_W-1:0] ^ w_seed_eff;
            if (w_accept) begin
                r_base   <= Base_Addr;
                r_last   <= Last_Addr;
                r_seed   <= Seed;
                r_verify <= Mode[1];
                r_err    <= '0;
                r_pass   <= 1'b0;
            end else begin
                r_err <= w_err_next;
                if (w_nstate == c_S_DONE) r_pass <= (w_err_next == 16'd0);
            end
        end
    end

`ifdef SRAM_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] r_first_addr;
    logic [DATA_W-1:0] r_first_data;

    // r_err is cleared on Start, so zero here means no earlier mismatch this run.
    always_ff @(posedge Clock) begin
        if (Reset || w_accept) begin
            r_first_addr <= '0;
            r_first_data <= '0;
        end else if (w_mismatch && (r_err == 16'd0)) begin
            r_first_addr <= r_addr;
            r_first_data <= SRAM_Data;
        end
    end

    assign First_Err_Addr = r_first_addr;
    assign First_Err_Data = r_first_data;
`endif

    assign SRAM_Data          = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign SRAM_Address       = r_addr;
    assign SRAM_Write_Enable  = r_we_n;
    assign SRAM_Output_Enable = r_oe_n;
    assign CS                 = r_cs_n;
    assign HbMask             = r_cs_n;
    assign LbMask             = r_cs_n;
    assign Busy               = r_busy;
    assign Done               = r_done;
    assign Pass               = r_pass;
    assign Err_Count          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sram_fill_verify_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_fill_verify_ctrl
// Description : Directed bench for sram_fill_verify_ctrl with a behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_fill_verify_ctrl;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  Mode;
    logic [17:0] Base_Addr;
    logic [17:0] Last_Addr;
    logic [15:0] Seed;
    logic        Busy;
    logic        Done;
    logic        Pass;
    logic [15:0] Err_Count;
    logic [17:0] SRAM_Address;
    wire  [15:0] SRAM_Data;
    logic        WE;
    logic        OE;
    logic        CS;
    logic        HbMask;
    logic        LbMask;
`ifdef SRAM_ERR_CAPTURE_EN
    logic [17:0] First_Err_Addr;
    logic [15:0] First_Err_Data;
`endif

    sram_fill_verify_ctrl #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(2)) u_dut (
        .Clock              (clk),
        .Reset              (Reset),
        .Start              (Start),
        .Mode               (Mode),
        .Base_Addr          (Base_Addr),
        .Last_Addr          (Last_Addr),
        .Seed               (Seed),
        .Busy               (Busy),
        .Done               (Done),
        .Pass               (Pass),
        .Err_Count          (Err_Count),
        .SRAM_Address       (SRAM_Address),
        .SRAM_Data          (SRAM_Data),
        .SRAM_Write_Enable  (WE),
        .SRAM_Output_Enable (OE),
        .CS                 (CS),
        .HbMask             (HbMask),
        .LbMask             (LbMask)
`ifdef SRAM_ERR_CAPTURE_EN
        ,
        .First_Err_Addr     (First_Err_Addr),
        .First_Err_Data     (First_Err_Data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural async SRAM with an optional stuck bit at address 0x12.
    logic [15:0] mem [0:(1<<18)-1];
    logic        flip_en;
    logic        we_q;
    int          cs_act;
    logic [17:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [15:0] rd_val;

    assign rd_val    = mem[SRAM_Address] ^ {15'b0, (flip_en && (SRAM_Address == 18'h12))};
    assign SRAM_Data = (!CS && !OE && WE) ? rd_val : 16'hzzzz;

    initial begin
        we_q   = 1'b1;
        cs_act = 0;
    end

    always @(posedge clk) begin
        if (!CS && !WE) mem[SRAM_Address] <= SRAM_Data;
        if (!CS && !WE && we_q) begin
            wr_addr_q.push_back(SRAM_Address);
            wr_data_q.push_back(SRAM_Data);
        end
        if (!CS) cs_act <= cs_act + 1;
        we_q <= WE;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [1:0] m, input logic [17:0] b, input logic [17:0] l,
                       input logic [15:0] s, output int cyc);
        Mode      = m;
        Base_Addr = b;
        Last_Addr = l;
        Seed      = s;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        cyc   = 1;
        while (Done !== 1'b1 && cyc < 1000) begin
            step();
            cyc++;
        end
        check("run_timeout", 32'(cyc < 1000), 32'd1);
    endtask

    int cyc;
    int act_before;

    initial begin
        Reset     = 1'b1;
        Start     = 1'b0;
        Mode      = 2'b00;
        Base_Addr = '0;
        Last_Addr = '0;
        Seed      = '0;
        flip_en   = 1'b0;
        repeat (3) step();

        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_pass", 32'(Pass), 32'd0);
        check("rst_err",  32'(Err_Count), 32'd0);
        check("rst_addr", 32'(SRAM_Address), 32'd0);
        check("rst_strobes", 32'({WE, OE, CS, HbMask, LbMask}), 32'h1F);
        check("rst_data_z", 32'(SRAM_Data === 16'hzzzz), 32'd1);
        Reset = 1'b0;
        step();

        // Fill then verify 0x10..0x13, clean memory
        run(2'b11, 18'h10, 18'h13, 16'h0000, cyc);
        check("m11_cycles", 32'(cyc), 32'd29);
        check("m11_pass",   32'(Pass), 32'd1);
        check("m11_err",    32'(Err_Count), 32'd0);
        check("m11_mem10",  32'(mem[18'h10]), 32'h0010);
        check("m11_mem13",  32'(mem[18'h13]), 32'h0013);
        step();
        check("done_pulse", 32'(Done), 32'd0);
        check("idle_busy",  32'(Busy), 32'd0);
        check("pass_held",  32'(Pass), 32'd1);

        // Same run with bit0 flipped on readback at 0x12
        flip_en = 1'b1;
        run(2'b11, 18'h10, 18'h13, 16'h0000, cyc);
        check("flip_cycles", 32'(cyc), 32'd29);
        check("flip_err",    32'(Err_Count), 32'd1);
        check("flip_pass",   32'(Pass), 32'd0);
`ifdef SRAM_ERR_CAPTURE_EN
        check("first_err_addr", 32'(First_Err_Addr), 32'h12);
        check("first_err_data", 32'(First_Err_Data), 32'h0013);
`endif
        flip_en = 1'b0;
        step();

        // Mode 00 start: ignored
        act_before = cs_act;
        Mode  = 2'b00;
        Start = 1'b1;
        repeat (10) step();
        Start = 1'b0;
        check("m00_busy",  32'(Busy), 32'd0);
        check("m00_act",   32'(cs_act), 32'(act_before));
        check("m00_err",   32'(Err_Count), 32'd1);
        check("m00_pass",  32'(Pass), 32'd0);

        // Fill-only wrapping through max address
        wr_addr_q.delete();
        wr_data_q.delete();
        run(2'b01, 18'h3FFFE, 18'h00001, 16'hA5A5, cyc);
        check("wrap_cycles", 32'(cyc), 32'd17);
        check("wrap_pass",   32'(Pass), 32'd1);
        check("wrap_err",    32'(Err_Count), 32'd0);
        check("wrap_nwr",    32'(wr_addr_q.size()), 32'd4);
        if (wr_addr_q.size() == 4) begin
            check("wrap_a0", 32'(wr_addr_q[0]), 32'h3FFFE);
            check("wrap_a1", 32'(wr_addr_q[1]), 32'h3FFFF);
            check("wrap_a2", 32'(wr_addr_q[2]), 32'h00000);
            check("wrap_a3", 32'(wr_addr_q[3]), 32'h00001);
            check("wrap_d0", 32'(wr_data_q[0]), 32'h5A5B);
            check("wrap_d1", 32'(wr_data_q[1]), 32'h5A5A);
            check("wrap_d2", 32'(wr_data_q[2]), 32'hA5A5);
            check("wrap_d3", 32'(wr_data_q[3]), 32'hA5A4);
        end
        step();

        // Start pulsed mid-run must not restart
        wr_addr_q.delete();
        wr_data_q.delete();
        Mode      = 2'b01;
        Base_Addr = 18'h40;
        Last_Addr = 18'h43;
        Seed      = 16'h0F0F;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        cyc   = 1;
        while (Done !== 1'b1 && cyc < 1000) begin
            if (cyc == 6) begin
                Start     = 1'b1;
                Mode      = 2'b10;
                Base_Addr = 18'h100;
            end else begin
                Start = 1'b0;
            end
            step();
            cyc++;
        end
        Start = 1'b0;
        check("busy_start_cycles", 32'(cyc), 32'd17);
        check("busy_start_nwr",    32'(wr_addr_q.size()), 32'd4);
        check("busy_start_mem43",  32'(mem[18'h43]), 32'h0F4C);
        step();

        // Reset asserted during the write pulse
        Mode      = 2'b01;
        Base_Addr = 18'h20;
        Last_Addr = 18'h21;
        Seed      = 16'h0000;
        Start     = 1'b1;
        step();
        Start = 1'b0;
        step();
        check("pulse_we", 32'({WE, CS}), 32'h0);
        Reset = 1'b1;
        step();
        check("midrst_we",   32'(WE), 32'd1);
        check("midrst_cs",   32'(CS), 32'd1);
        check("midrst_oe",   32'(OE), 32'd1);
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_z",    32'(SRAM_Data === 16'hzzzz), 32'd1);
        Reset = 1'b0;
        act_before = cs_act;
        repeat (4) step();
        check("midrst_quiet", 32'(cs_act), 32'(act_before));

        run(2'b11, 18'h30, 18'h30, 16'h1111, cyc);
        check("rerun_cycles", 32'(cyc), 32'd8);
        check("rerun_pass",   32'(Pass), 32'd1);
        check("rerun_mem30",  32'(mem[18'h30]), 32'h1121);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
